// File: rtl/card_shoe.sv
// Single-deck card shoe: builds a 52-card deck, shuffles it in place with a
// free-running Galois LFSR (masked-rejection Fisher-Yates) and deals one card per request.
module card_shoe #(
   parameter int          NUM_CARDS = 52,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_shuffle,
   input  logic       i_drawReq,
   output logic [5:0] o_card,
   output logic       o_cardValid,
   output logic       o_ready,
   output logic       o_empty,
   output logic [5:0] o_cardsLeft
);

   localparam logic [5:0]  LAST_IDX = 6'(NUM_CARDS - 1);
   localparam logic [5:0]  FULL_CNT = 6'(NUM_CARDS);
   localparam logic [15:0] SEED     = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
   localparam logic [15:0] TAPS     = 16'hB400;

   localparam logic [1:0] S_INIT    = 2'd0;
   localparam logic [1:0] S_SHUFFLE = 2'd1;
   localparam logic [1:0] S_READY   = 2'd2;
   localparam logic [1:0] S_EMPTY   = 2'd3;

   logic [5:0]  r_deck [0:NUM_CARDS-1];
   logic [1:0]  r_state;
   logic [5:0]  r_idx;
   logic [5:0]  r_top;
   logic [3:0]  r_rank;
   logic [1:0]  r_suit;
   logic [15:0] r_lfsr;
   logic [5:0]  r_card;
   logic        r_cardValid;
   logic [5:0]  r_cardsLeft;

   logic [5:0]  w_mask;
   logic [5:0]  w_j;
   logic        w_accept;

   // Smallest all-ones value covering v, i.e. 2^ceil(log2(v+1)) - 1.
   function automatic logic [5:0] cover_mask(input logic [5:0] v);
      return v | (v >> 1) | (v >> 2) | (v >> 3) | (v >> 4) | (v >> 5);
   endfunction

   assign w_mask   = cover_mask(r_idx);
   assign w_j      = r_lfsr[5:0] & w_mask;
   assign w_accept = (w_j <= r_idx);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= S_INIT;
         r_idx       <= 6'd0;
         r_top       <= 6'd0;
         r_rank      <= 4'd1;
         r_suit      <= 2'd0;
         r_lfsr      <= SEED;
         r_card      <= 6'd0;
         r_cardValid <= 1'b0;
         r_cardsLeft <= 6'd0;
      end else begin
         r_lfsr      <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? TAPS : 16'h0000);
         r_cardValid <= 1'b0;
         case (r_state)
            S_INIT: begin
               r_deck[r_idx] <= {r_suit, r_rank};
               if (r_rank == 4'd13) begin
                  r_rank <= 4'd1;
                  r_suit <= r_suit + 2'd1;
               end else begin
                  r_rank <= r_rank + 4'd1;
               end
               if (r_idx == LAST_IDX) r_state <= S_SHUFFLE;
               else                   r_idx   <= r_idx + 6'd1;
            end
            S_SHUFFLE: begin
               // Out-of-range j is rejected; retry with next cycle's LFSR value.
               if (w_accept) begin
                  r_deck[r_idx] <= r_deck[w_j];
                  r_deck[w_j]   <= r_deck[r_idx];
                  r_idx         <= r_idx - 6'd1;
                  if (r_idx == 6'd1) begin
                     r_state     <= S_READY;
                     r_top       <= 6'd0;
                     r_cardsLeft <= FULL_CNT;
                  end
               end
            end
            S_READY: begin
               if (i_shuffle) begin
                  r_state     <= S_SHUFFLE;
                  r_idx       <= LAST_IDX;
                  r_cardsLeft <= 6'd0;
               end else if (i_drawReq && (r_cardsLeft != 6'd0)) begin
                  r_card      <= r_deck[r_top];
                  r_cardValid <= 1'b1;
                  r_top       <= r_top + 6'd1;
                  r_cardsLeft <= r_cardsLeft - 6'd1;
                  if (r_cardsLeft == 6'd1) r_state <= S_EMPTY;
               end
            end
            S_EMPTY: begin
               if (i_shuffle) begin
                  r_state     <= S_SHUFFLE;
                  r_idx       <= LAST_IDX;
                  r_cardsLeft <= 6'd0;
               end
            end
            default: r_state <= S_INIT;
         endcase
      end
   end

   assign o_card      = r_card;
   assign o_cardValid = r_cardValid;
   assign o_ready     = (r_state == S_READY);
   assign o_empty     = (r_state == S_EMPTY);
   assign o_cardsLeft = r_cardsLeft;

endmodule

// File: tb/tb_card_shoe.sv
// Directed bench for card_shoe: reset state, shuffle timing, full deals against a
// software model of INIT + masked-rejection Fisher-Yates, and ignored-request cases.
module tb_card_shoe;

   logic       clk;
   logic       i_reset;
   logic       i_shuffle;
   logic       i_drawReq;
   logic [5:0] o_card;
   logic       o_cardValid;
   logic       o_ready;
   logic       o_empty;
   logic [5:0] o_cardsLeft;

   int checks   = 0;
   int failures = 0;

   logic [5:0] m_deck [52];
   int         m_cnt;

   card_shoe dut (
      .i_clk       (clk),
      .i_reset     (i_reset),
      .i_shuffle   (i_shuffle),
      .i_drawReq   (i_drawReq),
      .o_card      (o_card),
      .o_cardValid (o_cardValid),
      .o_ready     (o_ready),
      .o_empty     (o_empty),
      .o_cardsLeft (o_cardsLeft)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      if (l[0]) return (l >> 1) ^ 16'hB400;
      return l >> 1;
   endfunction

   // Deck after INIT plus shuffle, and number of shuffle cycles, for the default seed.
   task automatic compute_model();
      logic [15:0] l;
      logic [5:0]  t;
      int          i, j, m;
      for (int k = 0; k < 52; k++) begin
         t = 6'((k / 13) * 16 + (k % 13) + 1);
         m_deck[k] = t;
      end
      l = 16'hACE1;
      repeat (52) l = lfsr_step(l);
      i = 51;
      m_cnt = 0;
      while (i > 0) begin
         m = 1;
         while (m < i) m = (m << 1) | 1;
         j = int'(l[5:0]) & m;
         if (j <= i) begin
            t = m_deck[i];
            m_deck[i] = m_deck[j];
            m_deck[j] = t;
            i--;
         end
         l = lfsr_step(l);
         m_cnt++;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_card"},  32'(o_card), 32'd0);
      check({tag, "_valid"}, 32'(o_cardValid), 32'd0);
      check({tag, "_ready"}, 32'(o_ready), 32'd0);
      check({tag, "_empty"}, 32'(o_empty), 32'd0);
      check({tag, "_left"},  32'(o_cardsLeft), 32'd0);
   endtask

   // Wait for READY while pulsing draw/shuffle noise that must be ignored.
   task automatic wait_ready(input string tag, input bit use_model, input int min_edges);
      int n = 0;
      int stray = 0;
      while (n < 3000) begin
         @(negedge clk);
         n++;
         if (o_ready) break;
         if (o_cardValid || o_cardsLeft != 6'd0 || o_empty) stray++;
         i_drawReq = ((n % 5) == 2);
         i_shuffle = ((n % 37) == 20);
      end
      i_drawReq = 1'b0;
      i_shuffle = 1'b0;
      check({tag, "_ready"}, 32'(o_ready), 32'd1);
      check({tag, "_stray"}, 32'(stray), 32'd0);
      check({tag, "_minlen"}, 32'(n >= min_edges), 32'd1);
      if (use_model) check({tag, "_edges"}, 32'(n), 32'(52 + m_cnt));
      check({tag, "_left"}, 32'(o_cardsLeft), 32'd52);
      check({tag, "_empty"}, 32'(o_empty), 32'd0);
   endtask

   task automatic deal_all(input string tag, input bit use_model);
      logic [63:0] seen = '0;
      int dup = 0;
      int bad = 0;
      i_drawReq = 1'b1;
      for (int k = 0; k < 52; k++) begin
         @(negedge clk);
         check({tag, "_valid"}, 32'(o_cardValid), 32'd1);
         check({tag, "_left"},  32'(o_cardsLeft), 32'(51 - k));
         check({tag, "_empty"}, 32'(o_empty), 32'(k == 51));
         check({tag, "_ready"}, 32'(o_ready), 32'(k != 51));
         if (use_model) check({tag, "_order"}, 32'(o_card), 32'(m_deck[k]));
         if (o_card[3:0] < 4'd1 || o_card[3:0] > 4'd13) bad++;
         if (seen[o_card]) dup++;
         seen[o_card] = 1'b1;
      end
      @(negedge clk);
      check({tag, "_extra_valid"}, 32'(o_cardValid), 32'd0);
      check({tag, "_extra_left"},  32'(o_cardsLeft), 32'd0);
      check({tag, "_extra_empty"}, 32'(o_empty), 32'd1);
      i_drawReq = 1'b0;
      check({tag, "_dup"},   32'(dup), 32'd0);
      check({tag, "_rank"},  32'(bad), 32'd0);
      check({tag, "_count"}, 32'($countones(seen)), 32'd52);
   endtask

   initial begin
      i_reset   = 1'b1;
      i_shuffle = 1'b0;
      i_drawReq = 1'b0;
      compute_model();
      repeat (2) @(negedge clk);
      check_reset_outputs("por");
      i_reset = 1'b0;

      wait_ready("boot", 1'b1, 103);
      deal_all("deal1", 1'b1);

      // Draw in EMPTY is ignored
      i_drawReq = 1'b1;
      @(negedge clk);
      i_drawReq = 1'b0;
      check("empty_draw_valid", 32'(o_cardValid), 32'd0);
      check("empty_draw_left",  32'(o_cardsLeft), 32'd0);
      check("empty_draw_empty", 32'(o_empty), 32'd1);

      // Reshuffle from EMPTY
      i_shuffle = 1'b1;
      @(negedge clk);
      i_shuffle = 1'b0;
      check("resh_empty", 32'(o_empty), 32'd0);
      check("resh_ready", 32'(o_ready), 32'd0);
      check("resh_left",  32'(o_cardsLeft), 32'd0);
      wait_ready("resh", 1'b0, 51);

      // Shuffle and draw together in READY: shuffle wins
      i_shuffle = 1'b1;
      i_drawReq = 1'b1;
      @(negedge clk);
      i_shuffle = 1'b0;
      i_drawReq = 1'b0;
      check("both_valid", 32'(o_cardValid), 32'd0);
      check("both_ready", 32'(o_ready), 32'd0);
      check("both_left",  32'(o_cardsLeft), 32'd0);
      wait_ready("both", 1'b0, 51);
      deal_all("deal2", 1'b0);

      // Reset in the middle of a shuffle
      i_shuffle = 1'b1;
      @(negedge clk);
      i_shuffle = 1'b0;
      repeat (10) @(negedge clk);
      check("mid_ready", 32'(o_ready), 32'd0);
      i_reset = 1'b1;
      @(negedge clk);
      check_reset_outputs("midrst");
      i_reset = 1'b0;
      wait_ready("reboot", 1'b1, 103);
      deal_all("deal3", 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
